// File: rtl/led_chase_ctrl.sv
// Run/pause/step sequencer driving the 12-LED decoder with an active-low position code.
// Buttons are synchronized, debounced and edge-detected before reaching the FSM.
module led_chase_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned LAST      = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run_n,
    input  logic       btn_step_n,
    input  logic       btn_dir_n,
    input  logic [1:0] sw_speed,
    input  logic       mode_bounce,
    output logic [3:0] code_n,
    output logic [3:0] pos,
    output logic       dir,
    output logic       running
);

    localparam int unsigned NumBtn  = 3;
    localparam int unsigned BtnRun  = 0;
    localparam int unsigned BtnStep = 1;
    localparam int unsigned BtnDir  = 2;

    localparam logic [3:0]  LastPos = 4'(LAST);
    localparam logic [31:0] DbLimit = 32'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause
    } state_e;

    // ------------------------------------------------------------------
    // Button path: 2-FF synchronizer, debouncer, press-edge register
    // ------------------------------------------------------------------
    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q, sync2_q;
    logic [NumBtn-1:0] db_q, db_d;
    logic [NumBtn-1:0] db_prev_q;
    logic [NumBtn-1:0] ev_q;
    logic [31:0]       db_cnt_q [NumBtn];
    logic [31:0]       db_cnt_d [NumBtn];

    assign btn_raw = {btn_dir_n, btn_step_n, btn_run_n};

    // The count runs only while the synchronized level disagrees with the
    // accepted level; any agreement (a bounce) restarts it.
    always_comb begin
        for (int i = 0; i < NumBtn; i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] >= DbLimit) begin
                    db_d[i]     = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 32'd1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            db_q      <= '1;
            db_prev_q <= '1;
            ev_q      <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            ev_q      <= db_prev_q & ~db_q;
            for (int i = 0; i < NumBtn; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    logic run_ev, step_ev, dir_ev;

    assign run_ev  = ev_q[BtnRun];
    assign step_ev = ev_q[BtnStep];
    assign dir_ev  = ev_q[BtnDir];

    // ------------------------------------------------------------------
    // FSM and prescaler
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] period;
    logic        tick;
    logic        step_adv;

    assign period = TICK_DIV >> sw_speed;
    // >= rather than == so a shortened period fires at once instead of wrapping.
    assign tick   = (state_q == StRun) && (presc_q >= period - 32'd1);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        step_adv = 1'b0;
        unique case (state_q)
            StIdle: begin
                presc_d = '0;
                if (run_ev) begin
                    state_d = StRun;
                end else if (step_ev) begin
                    step_adv = 1'b1;
                    state_d  = StPause;
                end
            end
            StRun: begin
                presc_d = tick ? 32'd0 : presc_q + 32'd1;
                if (run_ev) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (run_ev) begin
                    state_d = StRun;
                end else if (step_ev) begin
                    step_adv = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                presc_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Position / direction update
    // ------------------------------------------------------------------
    logic [3:0] pos_q, pos_d;
    logic [3:0] code_n_q;
    logic       dir_q, dir_d;
    logic       running_q;
    logic       advance;
    logic       flip;

    assign advance = step_adv | tick;

    always_comb begin
        pos_d = pos_q;
        flip  = 1'b0;
        if (advance) begin
            if (!dir_q) begin
                if (pos_q < LastPos) begin
                    pos_d = pos_q + 4'd1;
                end else if (mode_bounce) begin
                    pos_d = LastPos - 4'd1;
                    flip  = 1'b1;
                end else begin
                    pos_d = 4'd0;
                end
            end else begin
                if (pos_q != 4'd0) begin
                    pos_d = pos_q - 4'd1;
                end else if (mode_bounce) begin
                    pos_d = 4'd1;
                    flip  = 1'b1;
                end else begin
                    pos_d = LastPos;
                end
            end
        end
        // A bounce flip and a dir press in the same cycle cancel out.
        dir_d = dir_q ^ flip ^ dir_ev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            pos_q     <= '0;
            code_n_q  <= 4'hF;
            dir_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            pos_q     <= pos_d;
            code_n_q  <= ~pos_d;
            dir_q     <= dir_d;
            running_q <= (state_d == StRun);
        end
    end

    assign pos     = pos_q;
    assign code_n  = code_n_q;
    assign dir     = dir_q;
    assign running = running_q;

endmodule

// File: doc/led_chase_ctrl.md
# led_chase_ctrl

Sequencer for the 12-LED one-hot decoder. It generates the 4-bit position code that the decoder consumes, in the same active-low form the board switches produce, so the decoder can be fed by this block instead of the switches. User input comes from active-low pushbuttons: run/pause, single-step and direction. The block handles debouncing, speed prescaling, wrap and bounce modes, and keeps the code inside the decoder's valid range 0..11.

## Interface
- TICK_DIV, 50_000_000: clock cycles per step at the slowest speed (sw_speed=0).
- DB_CYCLES, 1_000_000: consecutive stable cycles needed to accept a button change.
- LAST, 11: highest position, one less than the LED count.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_run_n  in  1  run/pause pushbutton, active-low, asynchronous to clk.
- btn_step_n  in  1  single-step pushbutton, active-low.
- btn_dir_n  in  1  direction-toggle pushbutton, active-low.
- sw_speed  in  2  step period is TICK_DIV >> sw_speed.
- mode_bounce  in  1  0 = wrap at the ends; 1 = reverse direction at the ends.
- code_n  out  4  ~pos, the decoder input, registered.
- pos  out  4  current position 0..LAST, registered.
- dir  out  1  0 = up, 1 = down.
- running  out  1  high in the RUN state.

## Operation
- Button path:
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized level has differed from it for DB_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press event is a 1-cycle pulse on a debounced 1→0 transition. Releases generate no event.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: run event → RUN. Step event → advance once, then PAUSE.
  - RUN: run event → PAUSE. Step events are ignored.
  - PAUSE: run event → RUN. Step event → advance once, stay in PAUSE.
- A dir event toggles dir in any state.
- Prescaler:
  - Counts only in RUN. It holds its value in PAUSE and clears in IDLE.
  - When the count reaches (TICK_DIV >> sw_speed) − 1, or any higher value, the block issues an advance and the counter returns to 0.
  - Because of the ≥ compare, a speed change mid-count takes effect immediately: if the period shrinks below the current count, the advance fires on the next cycle.
- Advance with dir=0:
  - pos < LAST: pos+1.
  - pos = LAST, wrap mode: 0.
  - pos = LAST, bounce mode: LAST−1, and dir flips.
- Advance with dir=1:
  - pos > 0: pos−1.
  - pos = 0, wrap mode: LAST.
  - pos = 0, bounce mode: 1, and dir flips.
- Simultaneous events:
  - An advance uses the dir value from before the cycle. The new dir is old_dir XOR bounce_flip XOR dir_event.
  - A run event and a step event in the same cycle: the run event is taken and the step event is dropped.
- pos never leaves 0..LAST, so code_n is never outside 4'hF..4'h4.

## Timing
- Reset (async assert, sync release) values: state IDLE, pos 0, code_n 4'hF, dir 0, running 0, prescaler 0, debounced levels 1 (released), no events.
- Reset during RUN: everything returns to the reset values immediately; no partial step is emitted.
- Latency from the first sampled low level of a clean press to the FSM/pos update: DB_CYCLES+3 cycles (2 sync + DB_CYCLES count + 1 event register).
- In RUN, successive advances are exactly TICK_DIV >> sw_speed cycles apart.
- The first RUN advance occurs that many cycles after RUN is entered, or after the remaining count when resuming from PAUSE.
- pos, code_n, dir and running update in the same clock edge; code_n always equals ~pos.

## Test plan
Common setup: TICK_DIV=16, DB_CYCLES=4, LAST=11.
- Reset, then a clean run press, sw_speed=0 → running=1 and pos steps 0,1,2… every 16 cycles; after 11, pos=0 and code_n 4'h4 → 4'hF.
- sw_speed=2 in RUN → advance period is 4 cycles. Switching to 3 when the count is 3 → advance on the next cycle, then every 2 cycles.
- Bounce mode, dir=0, starting at pos=10 → sequence 11,10,9 with dir=1 after reaching 11. At pos=0 going down → 1, with dir=0.
- Step button pulsed low for 3 cycles (less than DB_CYCLES) → no change. Held 10 cycles from IDLE → pos=1 and state PAUSE, exactly 7 cycles after the first low sample. Step pressed in RUN → ignored.
- Dir event arriving in the same cycle as a bounce flip at pos=11 → pos=10, and dir stays 0 (both flips cancel).
- rst_n pulsed low mid-RUN at pos=7 → code_n=4'hF and running=0 immediately. After release, no advance occurs without a new run press.
